// File: rtl/lwb_pkg.sv
// Shared encodings and helpers for the writeback load aligner.
package lwb_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_LO = 2'd1,
    ST_WAIT_HI = 2'd2
  } state_t;

  function automatic int size_bits(input logic [1:0] size);
    return 8 << size;
  endfunction

endpackage

// File: rtl/load_align_wb_lane_extract.sv
// Window shift, field mask and sign/zero extension of a loaded value.
module lane_extract
  import lwb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = $clog2(XLEN / 8)
) (
  input  logic [2*XLEN-1:0] window,
  input  logic [AW-1:0]     addr_lo,
  input  logic [1:0]        size,
  input  logic              sgn,
  output logic [XLEN-1:0]   result
);

  logic [2*XLEN-1:0] shifted;
  logic              fill;

  always_comb begin
    shifted = window >> {addr_lo, 3'b000};
    fill    = 1'b0;
    result  = '0;
    case (size)
      SZ_B:    fill = sgn & shifted[7];
      SZ_H:    fill = sgn & shifted[15];
      SZ_W:    fill = sgn & shifted[31];
      default: fill = sgn & shifted[XLEN-1];
    endcase
    for (int i = 0; i < XLEN; i++)
      result[i] = (i < size_bits(size)) ? shifted[i] : fill;
  end

endmodule

// File: rtl/load_align_wb.sv
// Writeback load aligner: collects one or two response beats and issues a
// registered single-cycle register-file write.
module load_align_wb
  import lwb_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int TAG_W = 5,
  localparam int AW    = $clog2(XLEN / 8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [AW-1:0]    req_addr_lo,
  input  logic             req_split,
  input  logic [TAG_W-1:0] req_tgt,
  input  logic             beat_valid,
  input  logic [XLEN-1:0]  beat_data,
  output logic             we,
  output logic [TAG_W-1:0] wb_tgt,
  output logic [XLEN-1:0]  wb_data,
  output logic             busy
);

  state_t            state, state_nxt;
  logic [1:0]        size_q, size_eff;
  logic              sgn_q, split_q, split_eff;
  logic [AW-1:0]     addr_q;
  logic [TAG_W-1:0]  tgt_q;
  logic [XLEN-1:0]   lo_buf, result;
  logic [2*XLEN-1:0] window;
  logic              accept, lo_load, emit;

  // A 32-bit datapath has no doubleword; a byte can never straddle beats.
  assign size_eff  = (XLEN == 32 && req_size == SZ_D) ? SZ_W : req_size;
  assign split_eff = req_split && (req_size != SZ_B);

  always_ff @(posedge clk) begin
    if (rst)         state <= ST_IDLE;
    else if (clk_en) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (req_valid) state_nxt = ST_WAIT_LO;
      ST_WAIT_LO: if (beat_valid) state_nxt = split_q ? ST_WAIT_HI : ST_IDLE;
      ST_WAIT_HI: if (beat_valid) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  always_comb begin
    req_ready = (state == ST_IDLE) && !rst && !flush;
    busy      = (state != ST_IDLE);
    accept    = req_ready && req_valid;
    lo_load   = (state == ST_WAIT_LO) && beat_valid && split_q && !flush;
    emit      = beat_valid && !flush &&
                (((state == ST_WAIT_LO) && !split_q) || (state == ST_WAIT_HI));
  end

  // Second beat supplies the upper half of the window; single beats see zeros above.
  assign window = (state == ST_WAIT_HI) ? {beat_data, lo_buf}
                                        : {{XLEN{1'b0}}, beat_data};

  lane_extract #(.XLEN(XLEN)) u_extract (
    .window  (window),
    .addr_lo (addr_q),
    .size    (size_q),
    .sgn     (sgn_q),
    .result  (result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      we      <= 1'b0;
      wb_tgt  <= '0;
      wb_data <= '0;
      lo_buf  <= '0;
      size_q  <= SZ_B;
      sgn_q   <= 1'b0;
      split_q <= 1'b0;
      addr_q  <= '0;
      tgt_q   <= '0;
    end else if (clk_en) begin
      we <= emit && (tgt_q != '0);
      if (emit) begin
        wb_tgt  <= tgt_q;
        wb_data <= result;
      end
      if (lo_load) lo_buf <= beat_data;
      if (accept) begin
        size_q  <= size_eff;
        sgn_q   <= req_signed;
        split_q <= split_eff;
        addr_q  <= req_addr_lo;
        tgt_q   <= req_tgt;
      end
    end
  end

endmodule

// File: tb/tb_load_align_wb.sv
// Directed bench for load_align_wb at XLEN=32 (index 0) and XLEN=64 (index 1).
module tb_load_align_wb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clk_en, flush;
  logic        req_valid[2], req_signed[2], req_split[2], beat_valid[2];
  logic [1:0]  req_size[2];
  logic [2:0]  req_addr[2];
  logic [4:0]  req_tgt[2];
  logic [63:0] beat_data[2];
  logic        req_ready[2], busy[2], we[2];
  logic [4:0]  wb_tgt[2];
  logic [31:0] wbd32;
  logic [63:0] wbd64;

  int checks = 0;
  int errors = 0;

  load_align_wb #(.XLEN(32), .TAG_W(5)) u32 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_size(req_size[0]),
    .req_signed(req_signed[0]), .req_addr_lo(req_addr[0][1:0]), .req_split(req_split[0]),
    .req_tgt(req_tgt[0]), .beat_valid(beat_valid[0]), .beat_data(beat_data[0][31:0]),
    .we(we[0]), .wb_tgt(wb_tgt[0]), .wb_data(wbd32), .busy(busy[0])
  );

  load_align_wb #(.XLEN(64), .TAG_W(5)) u64 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_size(req_size[1]),
    .req_signed(req_signed[1]), .req_addr_lo(req_addr[1]), .req_split(req_split[1]),
    .req_tgt(req_tgt[1]), .beat_valid(beat_valid[1]), .beat_data(beat_data[1]),
    .we(we[1]), .wb_tgt(wb_tgt[1]), .wb_data(wbd64), .busy(busy[1])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: gather bytes from the two-beat window, then extend arithmetically.
  function automatic logic [63:0] ref_load(input int xlen, input logic [63:0] lo,
                                           input logic [63:0] hi, input int addr,
                                           input int size, input bit sgn);
    logic [7:0]  bytes[16];
    logic [63:0] v;
    int lanes, sz, nb;
    lanes = xlen / 8;
    for (int k = 0; k < 16; k++) bytes[k] = 8'h00;
    for (int k = 0; k < lanes; k++) begin
      bytes[k]         = lo[8*k +: 8];
      bytes[lanes + k] = hi[8*k +: 8];
    end
    sz = (xlen == 32 && size == 3) ? 2 : size;
    nb = 1 << sz;
    v  = '0;
    for (int k = 0; k < nb; k++) v = v | (64'(bytes[addr + k]) << (8 * k));
    if (sgn && nb < 8 && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  // Transaction-level model: a pending request collects beats until it has enough.
  bit          m_pend[2], m_sgn[2], started;
  int          m_need[2], m_got[2], m_size[2], m_addr[2];
  logic [63:0] m_b[2][2];
  logic [4:0]  m_treq[2], m_tgt[2];
  logic        m_we[2];
  logic [63:0] m_data[2], m_bd;
  int          m_xl;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      m_xl = (d == 0) ? 32 : 64;
      m_bd = (d == 0) ? (beat_data[d] & 64'h0000_0000_FFFF_FFFF) : beat_data[d];
      if (rst) begin
        m_pend[d] = 0; m_we[d] = 1'b0; m_tgt[d] = '0; m_data[d] = '0;
      end else if (clk_en) begin
        m_we[d] = 1'b0;
        if (flush) m_pend[d] = 0;
        else if (m_pend[d]) begin
          if (beat_valid[d]) begin
            m_b[d][m_got[d]] = m_bd;
            m_got[d]++;
            if (m_got[d] == m_need[d]) begin
              m_data[d] = ref_load(m_xl, m_b[d][0], (m_need[d] == 2) ? m_b[d][1] : 64'h0,
                                   m_addr[d], m_size[d], m_sgn[d]);
              m_tgt[d]  = m_treq[d];
              m_we[d]   = (m_treq[d] != 5'd0);
              m_pend[d] = 0;
            end
          end
        end else if (req_valid[d]) begin
          m_pend[d] = 1;
          m_size[d] = int'(req_size[d]);
          m_sgn[d]  = req_signed[d];
          m_addr[d] = int'(req_addr[d]) & ((d == 0) ? 3 : 7);
          m_treq[d] = req_tgt[d];
          m_need[d] = (req_split[d] && req_size[d] != 2'd0) ? 2 : 1;
          m_got[d]  = 0;
        end
      end
    end
    if (rst) started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("model_we%0d", d), 64'(we[d]), 64'(m_we[d]));
        chk($sformatf("model_tgt%0d", d), 64'(wb_tgt[d]), 64'(m_tgt[d]));
        chk($sformatf("model_data%0d", d), (d == 0) ? {32'h0, wbd32} : wbd64, m_data[d]);
        chk($sformatf("model_busy%0d", d), 64'(busy[d]), 64'(m_pend[d]));
        chk($sformatf("model_ready%0d", d), 64'(req_ready[d]),
            64'(!m_pend[d] && !rst && !flush));
      end
    end
  end

  function automatic logic [63:0] dut_data(input int d);
    return (d == 0) ? {32'h0, wbd32} : wbd64;
  endfunction

  // Starts driving immediately; returns at the falling edge of the write cycle.
  task automatic do_load(input int d, input logic [1:0] sz, input logic sgn,
                         input logic [2:0] addr, input logic split, input logic [4:0] tgt,
                         input logic [63:0] b0, input logic [63:0] b1, input int stall,
                         input logic [63:0] exp_data, input string nm);
    req_valid[d] = 1'b1; req_size[d] = sz; req_signed[d] = sgn;
    req_addr[d] = addr; req_split[d] = split; req_tgt[d] = tgt;
    @(posedge clk); #1;
    req_valid[d] = 1'b0; beat_valid[d] = 1'b1; beat_data[d] = b0;
    if (stall > 0) begin
      clk_en = 1'b0;
      repeat (stall) begin
        @(posedge clk); #1;
        chk({nm, "_stall_we"}, 64'(we[d]), 64'h0);
      end
      clk_en = 1'b1;
    end
    @(posedge clk); #1;
    if (split && sz != 2'd0) begin
      beat_data[d] = b1;
      chk({nm, "_first_beat_we"}, 64'(we[d]), 64'h0);
      @(posedge clk); #1;
    end
    beat_valid[d] = 1'b0;
    @(negedge clk);
    chk({nm, "_we"}, 64'(we[d]), 64'(tgt != 5'd0));
    if (tgt != 5'd0) begin
      chk({nm, "_data"}, dut_data(d), exp_data);
      chk({nm, "_tgt"}, 64'(wb_tgt[d]), 64'(tgt));
    end
    chk({nm, "_ready"}, 64'(req_ready[d]), 64'h1);
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b0; flush = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_signed[d] = 1'b0; req_split[d] = 1'b0; beat_valid[d] = 1'b0;
      req_size[d] = 2'd0; req_addr[d] = 3'd0; req_tgt[d] = 5'd0; beat_data[d] = 64'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_we%0d", d), 64'(we[d]), 64'h0);
      chk($sformatf("rst_data%0d", d), dut_data(d), 64'h0);
      chk($sformatf("rst_busy%0d", d), 64'(busy[d]), 64'h0);
      chk($sformatf("rst_ready%0d", d), 64'(req_ready[d]), 64'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0; clk_en = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(req_ready[0]), 64'h1);

    // XLEN=32; consecutive calls exercise back-to-back acceptance in the write cycle.
    do_load(0, 2'd0, 1'b1, 3'd3, 1'b0, 5'd3,  64'h80FF1234, 64'h0, 0, 64'hFFFFFF80, "lb_s_a3");
    do_load(0, 2'd1, 1'b0, 3'd1, 1'b0, 5'd7,  64'h00ABCD00, 64'h0, 0, 64'h0000ABCD, "lhu_a1");
    do_load(0, 2'd2, 1'b0, 3'd2, 1'b1, 5'd9,  64'hBEEF0000, 64'h0000DEAD, 0, 64'hDEADBEEF, "lw_split");
    do_load(0, 2'd2, 1'b0, 3'd0, 1'b0, 5'd0,  64'h12345678, 64'h0, 0, 64'h0, "tgt0");
    do_load(0, 2'd3, 1'b1, 3'd0, 1'b0, 5'd10, 64'hCAFEF00D, 64'h0, 0, 64'hCAFEF00D, "sz3_as_w");
    do_load(0, 2'd0, 1'b1, 3'd3, 1'b1, 5'd11, 64'h81000000, 64'h0, 0, 64'hFFFFFF81, "lb_split_ign");
    do_load(0, 2'd1, 1'b1, 3'd3, 1'b1, 5'd12, 64'h34000000, 64'h000000F2, 0, 64'hFFFFF234, "lh_split");

    // Flush while the completing beat is presented.
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_size[0] = 2'd2; req_signed[0] = 1'b0;
    req_addr[0] = 3'd2; req_split[0] = 1'b1; req_tgt[0] = 5'd5;
    @(posedge clk); #1;
    req_valid[0] = 1'b0; beat_valid[0] = 1'b1; beat_data[0] = 64'h11110000;
    @(posedge clk); #1;
    beat_data[0] = 64'h00002222; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; beat_valid[0] = 1'b0;
    @(negedge clk);
    chk("flush_we", 64'(we[0]), 64'h0);
    chk("flush_busy", 64'(busy[0]), 64'h0);
    chk("flush_ready", 64'(req_ready[0]), 64'h1);
    do_load(0, 2'd0, 1'b1, 3'd1, 1'b0, 5'd4, 64'h00007F00, 64'h0, 0, 64'h0000007F, "lb_after_flush");

    // Reset in the middle of a load aborts it.
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_size[0] = 2'd2; req_addr[0] = 3'd0; req_split[0] = 1'b0;
    req_tgt[0] = 5'd6;
    @(posedge clk); #1;
    req_valid[0] = 1'b0; beat_valid[0] = 1'b1; beat_data[0] = 64'h55AA55AA; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; beat_valid[0] = 1'b0;
    @(negedge clk);
    chk("midrst_we", 64'(we[0]), 64'h0);
    chk("midrst_busy", 64'(busy[0]), 64'h0);
    chk("midrst_data", dut_data(0), 64'h0);
    @(posedge clk); #1;

    // XLEN=64.
    do_load(1, 2'd3, 1'b0, 3'd5, 1'b1, 5'd12, 64'h1122334455667788, 64'h99AABBCCDDEEFF00,
            3, 64'hCCDDEEFF00112233, "ld_split_a5_stall");
    do_load(1, 2'd3, 1'b0, 3'd4, 1'b1, 5'd13, 64'h1122334455667788, 64'h99AABBCCDDEEFF00,
            0, 64'hDDEEFF0011223344, "ld_split_a4");
    do_load(1, 2'd2, 1'b1, 3'd4, 1'b0, 5'd14, 64'h8000000000000000, 64'h0,
            0, 64'hFFFFFFFF80000000, "lw_s_64");
    do_load(1, 2'd1, 1'b0, 3'd7, 1'b1, 5'd15, 64'hAB00000000000000, 64'h00000000000000CD,
            0, 64'h000000000000CDAB, "lhu_split_64");
    do_load(1, 2'd0, 1'b0, 3'd6, 1'b0, 5'd1, 64'h00FE000000000000, 64'h0,
            0, 64'h00000000000000FE, "lbu_64");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
